// File: rtl/mult_issue_pkg.sv
// Shared types and sizing helpers for the multiplier issue queue.
package mult_issue_pkg;

    localparam int DEF_DEPTH = 4;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    localparam int PTR_W = ptr_w(DEF_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARM,
        WAIT,
        OUT
    } state_t;

endpackage

// File: rtl/mult_issue_queue_sync_fifo.sv
// Power-of-two synchronous FIFO; pushes while full and pops while empty are ignored.
module sync_fifo
    import mult_issue_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [ptr_w(DEPTH):0]    count
);

    localparam int AW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read that matters.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mult_issue_queue.sv
// Operand FIFO plus start/done issue FSM in front of a sequential multiplier.
// Optional MULT_ISSUE_ZERO_BYPASS_EN: zero-operand entries skip the multiplier.
//
//   state | meaning
//   IDLE  | waiting for a buffered entry; pops head into mul_a/mul_b
//   ISSUE | mul_start pulse
//   ARM   | mul_done ignored (may be stale from previous op)
//   WAIT  | waiting for mul_done, captures product
//   OUT   | out_valid held until out_ready
module mult_issue_queue
    import mult_issue_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH-1:0]       out_product,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic                     mul_done,
    input  logic [2*WIDTH-1:0]       mul_product,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0]   out_product_q, out_product_d;
    logic                 out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]   head;
    logic [WIDTH-1:0]     head_a, head_b;
    logic                 pop, full, empty, zero_head;

    sync_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (pop),
        .wdata ({in_a, in_b}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign head_a = head[2*WIDTH-1:WIDTH];
    assign head_b = head[WIDTH-1:0];

`ifdef MULT_ISSUE_ZERO_BYPASS_EN
    assign zero_head = (head_a == '0) || (head_b == '0);
`else
    assign zero_head = 1'b0;
`endif

    assign in_ready    = !full;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign mul_start   = (state_q == ISSUE);
    assign busy        = (state_q != IDLE) || !empty;

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        out_product_d = out_product_q;
        out_valid_d   = out_valid_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    mul_a_d = head_a;
                    mul_b_d = head_b;
                    if (zero_head) begin
                        out_product_d = '0;
                        out_valid_d   = 1'b1;
                        state_d       = OUT;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = ARM;
            ARM:   state_d = WAIT;
            WAIT: begin
                if (mul_done) begin
                    out_product_d = mul_product;
                    out_valid_d   = 1'b1;
                    state_d       = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            out_product_q <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            out_product_q <= out_product_d;
            out_valid_q   <= out_valid_d;
        end
    end

endmodule

// File: doc/mult_issue_queue.md
# mult_issue_queue

Operand buffer and issue controller placed directly upstream of `sequential_multiplier`. It accepts operand pairs over a valid/ready stream and buffers them in a DEPTH-entry FIFO. It issues them one at a time to the multiplier using its `start`/`done` protocol, then returns each product on a valid/ready output stream in order. It lets producers stream operands without tracking multiplier occupancy.

## Interface
- `WIDTH`, 8: operand width; must match the multiplier's `WIDTH`.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.

- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  FIFO not full.
- `in_a`, `in_b`  in  WIDTH  operands.
- `out_valid`  out  1  product valid.
- `out_ready`  in  1  consumer accepts product.
- `out_product`  out  2*WIDTH  registered product.
- `mul_start`  out  1  one-cycle start pulse to the multiplier.
- `mul_a`, `mul_b`  out  WIDTH  operands to the multiplier.
- `mul_done`  in  1  multiplier completion.
- `mul_product`  in  2*WIDTH  multiplier result.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `busy`  out  1  state ≠ IDLE or count ≠ 0.

## Operation
- **Push:** `in_valid && in_ready` writes `{in_a,in_b}` at the write pointer.
- **`in_ready`:** `in_ready = (count != DEPTH)`. It depends only on registered `count`. When the FIFO is full, no push occurs, even in a cycle that pops.
- **Pointers:** pointers wrap modulo DEPTH. `count` increments on push, decrements on pop, and is unchanged on a simultaneous push and pop.
- **FSM states:** IDLE, ISSUE, ARM, WAIT, OUT.
- **IDLE:** if `count != 0`, pop the head into `mul_a`/`mul_b` and go to ISSUE.
- **ISSUE:** `mul_start = 1` for this cycle only; go to ARM.
- **ARM:** ignore `mul_done`, which may still be high from the previous operation; go to WAIT.
- **WAIT:** on `mul_done = 1`, capture `mul_product` into `out_product`, set `out_valid <= 1`, and go to OUT.
- **OUT:** hold `out_valid` and `out_product` stable until `out_ready`. On the handshake, clear `out_valid` and go to IDLE.
- **Stability:** `mul_a`/`mul_b` stay stable from ISSUE until the next pop.
- **Ordering:** results leave in push order. Only one operation is in flight.
- **Widths:** no width conversion; the product is passed through at 2*WIDTH.
- **Reset:**
  - state IDLE; pointers and `count` = 0.
  - `in_ready` = 1.
  - `out_valid`, `mul_start`, `busy` = 0.
  - `out_product`, `mul_a`, `mul_b` = 0.
- **Reset mid-operation:** the in-flight operation and all buffered entries are discarded. A stale `mul_done` arriving after reset is ignored, because it is only sampled in WAIT.

## Timing
- **Push latency:** a push at cycle 0 into an empty FIFO while IDLE gives the pop at cycle 1 and `mul_start` at cycle 2.
- **Operation latency:** with `mul_done` seen at cycle N, `out_valid` is high at N+1.
- **Next issue:** after the output handshake at cycle M, the next `mul_start` is at M+2 (IDLE at M+1, ISSUE at M+2).
- **Busy:** `busy` is registered-equivalent, derived only from state and `count`; it is never combinational from inputs.
- **Output independence:** no output depends combinationally on `in_valid`, `out_ready`, or `mul_done`.

## Configuration
- **`MULT_ISSUE_ZERO_BYPASS_EN`:**
  - **Defined:** in IDLE, a head entry with `a == 0` or `b == 0` is popped and goes directly to OUT with `out_product = 0` and `out_valid = 1` on the next cycle. No `mul_start` is issued for it.
  - **Undefined:** zero operands are issued to the multiplier like any other entry.
  - Ordering and port list are identical in both builds.

## Structure
- **Package `mult_issue_pkg`:**
  - state enum typedef (IDLE, ISSUE, ARM, WAIT, OUT).
  - localparam for the pointer width, `$clog2(DEPTH)`.
- **Sub-module `sync_fifo`:**
  - parameters WIDTH=2*WIDTH, DEPTH.
  - ports: push/pop, full/empty, count.
  - owns the pointers and storage.
- **Top level:** FSM, operand/output registers, and bypass logic.

## Test plan
- **Single op:** push 5×3 → one `mul_start` pulse at cycle 2, `mul_a=5`, `mul_b=3`; `out_product=15` with `out_valid` held until `out_ready`.
- **Fill:** push 4 pairs back-to-back (5×3, 15×10, 255×255, 7×9) while the multiplier is busy → `in_ready` low after the 4th push, `count=4`; outputs in order 15, 150, 65025, 63.
- **Backpressure:** hold `out_ready=0` for 20 cycles in OUT → `out_product` stable and no further `mul_start`; on release, the next `mul_start` is 2 cycles after the handshake.
- **Zero operand:** push 10×0.
  - With `MULT_ISSUE_ZERO_BYPASS_EN`: product 0, no `mul_start`.
  - Without it: product 0 via the multiplier.
- **Stale done:** keep `mul_done` high continuously from the previous op → ARM masks it; completion is taken only in WAIT and gives exactly one output per push.
- **Reset mid-WAIT:** assert `rst` with 3 entries queued → next cycle `count=0`, `out_valid=0`, `busy=0`; a later `mul_done` produces no output.
